// File: rtl/digit_serdes.sv
// Word <-> digit-serial converter, LSB digit first; load sign/zero-extends, store yields a byte mask.
// Serialise: first digit 1 cycle after start, done after BEATS; deserialise: done after BEATS+1; start ignored while busy or in FINISH.
module digit_serdes #(
    parameter int D_WIDTH = 32,
    parameter int DIGIT_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [2:0]           func,
    input  logic [1:0]           byte_off,
    input  logic [D_WIDTH-1:0]   word_in,
    input  logic [DIGIT_W-1:0]   digit_in,
    output logic [DIGIT_W-1:0]   digit_out,
    output logic                 digit_valid,
    output logic [D_WIDTH-1:0]   word_out,
    output logic [D_WIDTH/8-1:0] wr_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 misaligned
);
    localparam int BEATS  = D_WIDTH / DIGIT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NBYTES = D_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] shreg_q, shreg_d;
    logic               mode_q, mode_d;
    logic [1:0]         off_q, off_d;
    logic [NBYTES-1:0]  bmask_q, bmask_d;
    logic [D_WIDTH-1:0] word_out_q, word_out_d;
    logic [NBYTES-1:0]  wr_mask_q, wr_mask_d;
    logic               mis_q, mis_d;

    logic               is_byte, is_half, is_word, mis_req, last, fill;
    logic [D_WIDTH-1:0] shifted, bit_mask, load_val, shift_in;
    logic [NBYTES-1:0]  bmask_sel;

    assign is_byte = (func[1:0] == 2'b00);
    assign is_half = (func[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;
    assign mis_req = (is_half && byte_off[0]) || (is_word && (byte_off != 2'd0));
    assign last    = (cnt_q == CNT_W'(BEATS - 1));

    // Load path: bring the addressed lane down to bit 0, then extend above the access size.
    assign shifted = word_in >> {byte_off, 3'b000};
    always_comb begin
        bit_mask  = '1;
        bmask_sel = '1;
        fill      = 1'b0;
        if (is_byte) begin
            bit_mask  = D_WIDTH'(8'hFF);
            bmask_sel = NBYTES'(1);
            fill      = shifted[7];
        end else if (is_half) begin
            bit_mask  = D_WIDTH'(16'hFFFF);
            bmask_sel = NBYTES'(3);
            fill      = shifted[15];
        end
        if (func[2]) begin
            fill = 1'b0;
        end
    end
    assign load_val = (shifted & bit_mask) | ({D_WIDTH{fill}} & ~bit_mask);
    assign shift_in = (shreg_q >> DIGIT_W) | (D_WIDTH'(digit_in) << (D_WIDTH - DIGIT_W));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        mode_d     = mode_q;
        off_d      = off_q;
        bmask_d    = bmask_q;
        word_out_d = word_out_q;
        wr_mask_d  = wr_mask_q;
        mis_d      = mis_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mis_req) begin
                        mis_d = 1'b1;
                    end else begin
                        mis_d     = 1'b0;
                        state_d   = S_SHIFT;
                        cnt_d     = '0;
                        mode_d    = mode;
                        off_d     = byte_off;
                        bmask_d   = bmask_sel;
                        wr_mask_d = '0;
                        shreg_d   = mode ? '0 : load_val;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = mode_q ? shift_in : (shreg_q >> DIGIT_W);
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    if (mode_q) begin
                        // Capture the store result as the last digit lands so it is visible in FINISH.
                        state_d    = S_FINISH;
                        word_out_d = shift_in << {off_q, 3'b000};
                        wr_mask_d  = bmask_q << off_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            mode_q     <= 1'b0;
            off_q      <= 2'd0;
            bmask_q    <= '0;
            word_out_q <= '0;
            wr_mask_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            mode_q     <= mode_d;
            off_q      <= off_d;
            bmask_q    <= bmask_d;
            word_out_q <= word_out_d;
            wr_mask_q  <= wr_mask_d;
            mis_q      <= mis_d;
        end
    end

    assign busy        = (state_q == S_SHIFT);
    assign digit_valid = busy && !mode_q;
    assign digit_out   = digit_valid ? shreg_q[DIGIT_W-1:0] : '0;
    assign done        = (digit_valid && last) || (state_q == S_FINISH);
    assign word_out    = word_out_q;
    assign wr_mask     = wr_mask_q;
    assign misaligned  = mis_q;
endmodule

// File: tb/tb_digit_serdes.sv
// Directed bench driving bit-, nibble- and byte-serial instances from shared control inputs.
module tb_digit_serdes;
    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [2:0]  func;
    logic [1:0]  byte_off;
    logic [31:0] word_in;
    logic [0:0]  di1, do1;
    logic [3:0]  di4, do4;
    logic [7:0]  di8, do8;
    logic [2:0]  dv, dn, bs, ms;
    logic [31:0] wo [3];
    logic [3:0]  wm [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    digit_serdes #(.D_WIDTH(32), .DIGIT_W(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .func(func), .byte_off(byte_off),
        .word_in(word_in), .digit_in(di1), .digit_out(do1), .digit_valid(dv[0]),
        .word_out(wo[0]), .wr_mask(wm[0]), .busy(bs[0]), .done(dn[0]), .misaligned(ms[0]));
    digit_serdes #(.D_WIDTH(32), .DIGIT_W(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .func(func), .byte_off(byte_off),
        .word_in(word_in), .digit_in(di4), .digit_out(do4), .digit_valid(dv[1]),
        .word_out(wo[1]), .wr_mask(wm[1]), .busy(bs[1]), .done(dn[1]), .misaligned(ms[1]));
    digit_serdes #(.D_WIDTH(32), .DIGIT_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .func(func), .byte_off(byte_off),
        .word_in(word_in), .digit_in(di8), .digit_out(do8), .digit_valid(dv[2]),
        .word_out(wo[2]), .wr_mask(wm[2]), .busy(bs[2]), .done(dn[2]), .misaligned(ms[2]));

    typedef struct {
        logic        mode;
        logic [2:0]  func;
        logic [1:0]  off;
        logic [31:0] din;
        logic        mis;
        logic [31:0] exp_word;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic m, input logic [2:0] f, input logic [1:0] o, input logic [31:0] w);
        @(posedge clk);
        #1;
        mode = m; func = f; byte_off = o; word_in = w; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v, input int inj_k);
        logic [31:0] rec [3];
        logic [31:0] wod [3];
        logic [3:0]  wmd [3];
        logic [3:0]  wm1 [3];
        logic        bsd [3];
        int          nd [3], dk [3], fk [3], nv [3], bt [3];
        logic [31:0] d;
        logic        anyb;
        bt = '{32, 8, 4};
        d  = v.din;
        anyb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rec[i] = '0; wod[i] = '0; wmd[i] = '0; wm1[i] = '0; bsd[i] = 1'b1;
            nd[i] = 0; dk[i] = 0; fk[i] = 0; nv[i] = 0;
        end
        issue(v.mode, v.func, v.off, v.mode ? 32'h0 : v.din);
        if (v.mis) begin
            repeat (3) begin
                @(negedge clk);
                anyb = anyb | (|bs) | (|dn);
            end
            chk($sformatf("v%0d misaligned", idx), {61'd0, ms}, 64'h7);
            chk($sformatf("v%0d mis_busy_done", idx), {63'd0, anyb}, 64'd0);
        end else begin
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (dv[i]) begin
                        nv[i]++;
                        if (fk[i] == 0) fk[i] = k;
                    end
                    if (dn[i]) begin
                        nd[i]++; dk[i] = k; wod[i] = wo[i]; wmd[i] = wm[i]; bsd[i] = bs[i];
                    end
                    if (k == 1) wm1[i] = wm[i];
                end
                if (dv[0]) rec[0] = {do1, rec[0][31:1]};
                if (dv[1]) rec[1] = {do4, rec[1][31:4]};
                if (dv[2]) rec[2] = {do8, rec[2][31:8]};
                di1 = (k <= 32) ? d[k-1 +: 1] : 1'b0;
                di4 = (k <= 8) ? d[(k-1)*4 +: 4] : 4'h0;
                di8 = (k <= 4) ? d[(k-1)*8 +: 8] : 8'h0;
                if (inj_k != 0 && k == inj_k) begin
                    start = 1'b1; word_in = 32'h0;
                end
                if (inj_k != 0 && k == inj_k + 1) start = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("v%0d u%0d done_count", idx, i), 64'(nd[i]), 64'd1);
                chk($sformatf("v%0d u%0d misaligned", idx, i), {63'd0, ms[i]}, 64'd0);
                if (!v.mode) begin
                    chk($sformatf("v%0d u%0d word", idx, i), {32'd0, rec[i]}, {32'd0, v.exp_word});
                    chk($sformatf("v%0d u%0d digits", idx, i), 64'(nv[i]), 64'(bt[i]));
                    chk($sformatf("v%0d u%0d done_cycle", idx, i), 64'(dk[i]), 64'(bt[i]));
                    chk($sformatf("v%0d u%0d first_digit", idx, i), 64'(fk[i]), 64'd1);
                    chk($sformatf("v%0d u%0d mask_cleared", idx, i), {60'd0, wm1[i]}, 64'd0);
                end else begin
                    chk($sformatf("v%0d u%0d word_out", idx, i), {32'd0, wod[i]}, {32'd0, v.exp_word});
                    chk($sformatf("v%0d u%0d wr_mask", idx, i), {60'd0, wmd[i]}, {60'd0, v.exp_mask});
                    chk($sformatf("v%0d u%0d done_cycle", idx, i), 64'(dk[i]), 64'(bt[i] + 1));
                    chk($sformatf("v%0d u%0d busy_at_done", idx, i), {63'd0, bsd[i]}, 64'd0);
                    chk($sformatf("v%0d u%0d no_valid", idx, i), 64'(nv[i]), 64'd0);
                    chk($sformatf("v%0d u%0d word_hold", idx, i), {32'd0, wo[i]}, {32'd0, v.exp_word});
                end
            end
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [11:0] vm, dmask;
        logic        anyb;
        int          nd4, nd1, extra8;

        tbl[0]  = '{1'b0, 3'b000, 2'd2, 32'h00F00000, 1'b0, 32'hFFFFFFF0, 4'h0};
        tbl[1]  = '{1'b0, 3'b101, 2'd2, 32'h80011234, 1'b0, 32'h00008001, 4'h0};
        tbl[2]  = '{1'b0, 3'b010, 2'd1, 32'h12345678, 1'b1, 32'h0,        4'h0};
        tbl[3]  = '{1'b0, 3'b010, 2'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'h0};
        tbl[4]  = '{1'b1, 3'b001, 2'd2, 32'h0000BEEF, 1'b0, 32'hBEEF0000, 4'hC};
        tbl[5]  = '{1'b0, 3'b100, 2'd3, 32'h80FFFFFF, 1'b0, 32'h00000080, 4'h0};
        tbl[6]  = '{1'b0, 3'b001, 2'd3, 32'h0000FFFF, 1'b1, 32'h0,        4'h0};
        tbl[7]  = '{1'b1, 3'b000, 2'd3, 32'h000000A5, 1'b0, 32'hA5000000, 4'h8};
        tbl[8]  = '{1'b0, 3'b001, 2'd0, 32'h12348765, 1'b0, 32'hFFFF8765, 4'h0};
        tbl[9]  = '{1'b1, 3'b010, 2'd0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4'hF};
        tbl[10] = '{1'b0, 3'b101, 2'd1, 32'h00000000, 1'b1, 32'h0,        4'h0};
        tbl[11] = '{1'b1, 3'b000, 2'd1, 32'h00000012, 1'b0, 32'h00001200, 4'h2};
        tbl[12] = '{1'b0, 3'b000, 2'd1, 32'h00007F00, 1'b0, 32'h0000007F, 4'h0};
        tbl[13] = '{1'b1, 3'b101, 2'd0, 32'h00001234, 1'b0, 32'h00001234, 4'h3};
        tbl[14] = '{1'b0, 3'b011, 2'd0, 32'h01234567, 1'b0, 32'h01234567, 4'h0};
        tbl[15] = '{1'b0, 3'b010, 2'd2, 32'h00000000, 1'b1, 32'h0,        4'h0};
        tbl[16] = '{1'b0, 3'b110, 2'd0, 32'hF00000AB, 1'b0, 32'hF00000AB, 4'h0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; func = 3'b000; byte_off = 2'd0;
        word_in = 32'h0; di1 = '0; di4 = '0; di8 = '0;
        repeat (2) @(negedge clk);
        chk("reset ctl", {52'd0, dv, dn, bs, ms}, 64'd0);
        chk("reset digits", {51'd0, do1, do4, do8}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset u%0d word_out", i), {32'd0, wo[i]}, 64'd0);
            chk($sformatf("reset u%0d wr_mask", i), {60'd0, wm[i]}, 64'd0);
        end
        rst = 1'b0;

        for (int n = 0; n < 17; n++) run_vec(n, tbl[n], 0);

        // Mid-transfer start must neither restart nor add a done pulse.
        run_vec(100, tbl[3], 3);

        // Reset at beat 5 aborts without a done pulse.
        issue(1'b0, 3'b010, 2'd0, 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort ctl", {52'd0, dv, dn, bs, ms}, 64'd0);
        chk("abort digits", {51'd0, do1, do4, do8}, 64'd0);
        chk("abort u0 word_out", {32'd0, wo[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        anyb = 1'b0;
        repeat (40) begin
            @(negedge clk);
            anyb = anyb | (|dn) | (|bs);
        end
        chk("abort no_done", {63'd0, anyb}, 64'd0);

        // Byte-serial back-to-back: second start in the cycle after done.
        r = '0; vm = '0; dmask = '0; nd4 = 0; nd1 = 0; extra8 = 0;
        issue(1'b0, 3'b010, 2'd0, 32'h11223344);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (dv[2]) r = {do8, r[63:8]};
            vm[k-1]    = dv[2];
            dmask[k-1] = dn[2];
            if (dn[1]) nd4++;
            if (dn[0]) nd1++;
            if (k == 5) begin
                start = 1'b1; word_in = 32'h55667788;
            end
            if (k == 6) start = 1'b0;
        end
        repeat (40) begin
            @(negedge clk);
            if (dn[1]) nd4++;
            if (dn[0]) nd1++;
            if (dn[2]) extra8++;
        end
        chk("b2b digits", r, 64'h5566778811223344);
        chk("b2b valid_pattern", {52'd0, vm}, 64'h1EF);
        chk("b2b done_pattern", {52'd0, dmask}, 64'h108);
        chk("b2b extra_done", 64'(extra8), 64'd0);
        chk("b2b u4 done_count", 64'(nd4), 64'd1);
        chk("b2b u1 done_count", 64'(nd1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/digit_serdes.md
Name: digit_serdes

Overview:
Parametrised successor to the bit-serial core's data serialiser/deserialiser. It moves a memory word to and from the datapath DIGIT_W bits per cycle, LSB digit first. Loads sign- or zero-extend; stores produce a byte write mask. Misaligned accesses are detected before any transfer starts. It sits between the block RAM data bus and the serial ALU/register file, and DIGIT_W lets the same core be built bit-serial, nibble-serial or byte-serial.

Parameters:
D_WIDTH, 32, word width in bits; multiple of 8.
DIGIT_W, 1, bits transferred per cycle; must divide 8.
BEATS, D_WIDTH/DIGIT_W, derived localparam; cycles per transfer.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a transfer; sampled only when busy=0.
mode  input  1  0 = serialise (load path), 1 = deserialise (store path).
func  input  3  RISC-V funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
byte_off  input  2  address bits [1:0] of the access.
word_in  input  D_WIDTH  memory read word; sampled on accepted start when mode=0.
digit_in  input  DIGIT_W  serial data from the datapath when mode=1.
digit_out  output  DIGIT_W  serial data to the datapath when mode=0.
digit_valid  output  1  digit_out is meaningful this cycle.
word_out  output  D_WIDTH  assembled, lane-aligned store word.
wr_mask  output  D_WIDTH/8  byte-enable mask for word_out.
busy  output  1  transfer in progress.
done  output  1  one-cycle completion pulse.
misaligned  output  1  last start request was misaligned.

Behaviour:
- Reset (asynchronous): all outputs 0, beat counter 0, state IDLE. Asserting reset mid-transfer aborts it; no done pulse is produced.
- States: IDLE, SHIFT, FINISH.
- Size decode: func[1:0] 00 = 8 bits, 01 = 16 bits, 10 = 32 bits. func[2]=1 means unsigned. Any other func value is treated as a word.
- Misalignment: a halfword with byte_off[0]=1, or a word with byte_off≠0.
  - On a misaligned start in IDLE: misaligned=1, busy stays 0, no transfer, no done.
  - misaligned holds until the next accepted start, which clears it.
- IDLE→SHIFT on an aligned start. busy=1 from the following cycle. The counter loads 0.
- Serialise (mode=0):
  - On the start edge, latch shreg = word_in >> (8·byte_off), then mask to the access size.
  - For signed sizes, fill the upper bits with the size's MSB; for unsigned, fill with 0.
  - In SHIFT, digit_valid=1 and digit_out=shreg[DIGIT_W-1:0] every cycle; shreg shifts right by DIGIT_W.
  - Exactly BEATS digits are emitted on consecutive cycles.
  - done=1 in the same cycle as the last digit. State then returns directly to IDLE; FINISH is not used.
- Deserialise (mode=1):
  - In SHIFT, digit_in is shifted into the MSB end of shreg each cycle for BEATS cycles. digit_valid stays 0.
  - After the last sample, enter FINISH for one cycle. In FINISH:
    - word_out = shreg << (8·byte_off), truncated to D_WIDTH.
    - wr_mask = size mask (0001 / 0011 / 1111 pattern) << byte_off.
    - done=1 and busy=0 (busy is already 0 in this cycle).
  - word_out and wr_mask hold until the next accepted start, which clears wr_mask to 0.
- start while busy=1 is ignored. It is not queued.
- start in the FINISH cycle is ignored.
- A new transfer may be accepted in the cycle after done.
- Latency:
  - Serialise: first digit 1 cycle after start; done BEATS cycles after start.
  - Deserialise: done BEATS+1 cycles after start.
- Counter width is clog2(BEATS). The counter wraps to 0 at BEATS-1 and does not count in IDLE.

Test Plan:
- DIGIT_W=1, mode=0, func=000, byte_off=2, word_in=0x00F00000 → 32 digits of 0xFFFFFFF0 LSB first; done on the 32nd digit cycle; misaligned=0.
- DIGIT_W=4, mode=0, func=101, byte_off=2, word_in=0x8001_1234 → 8 nibbles reconstruct 0x00008001; done 8 cycles after start.
- DIGIT_W=1, mode=1, func=001, byte_off=2, digit_in stream of 0x0000BEEF → done 33 cycles after start; word_out=0xBEEF0000; wr_mask=1100.
- func=010, byte_off=1, start → misaligned=1, busy and done stay 0; a following aligned start clears misaligned.
- A start pulse mid-transfer is ignored, with the done count unchanged; rst asserted at beat 5 → all outputs 0 immediately, and no done pulse follows.
- DIGIT_W=8, back-to-back serialise transfers with start asserted the cycle after done → second transfer accepted; 4 digits each with no gap beyond one cycle.
